piso_shift_tx: RTL

Parallel-in, serial-out shift transmitter. It is the sending end of the serial shift chain: it accepts a WIDTH-bit word through a valid/ready load handshake and drives it out one bit per enabled clock, with frame and last-bit markers. Back-to-back words stream with no idle bubble. It sits in front of serial-in shift-register receivers.

---
 rtl/piso_shift_tx.sv | 82 ++++++++
 1 files changed

// File: rtl/piso_shift_tx.sv
// Parallel-in, serial-out shift transmitter with a valid/ready load port.
// Streams one bit per enabled clock and marks the first and last bit of each word.
module piso_shift_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             last,
  output logic             dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  // Load handshake: a word is accepted at a rising edge where load_valid &&
  // load_ready. load_ready is high in IDLE, or on the final bit of a word
  // when that bit is about to retire (shift_en=1), so words chain gaplessly.
  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_sout;
  logic             r_valid;

  logic             w_last;
  logic             w_accept;
  logic             w_first_bit;
  logic [WIDTH-1:0] w_load_rest;

  assign w_last      = r_valid && (r_cnt == LAST_CNT);
  assign load_ready  = (r_state == IDLE) || ((r_state == SHIFT) && w_last && shift_en);
  assign w_accept    = load_valid && load_ready;

  // The first bit goes straight to sout; the remainder is pre-aligned so the
  // next bit to send always sits at the outgoing end of r_shift.
  assign w_first_bit = MSB_FIRST ? din[WIDTH-1] : din[0];
  assign w_load_rest = MSB_FIRST ? (din << 1) : (din >> 1);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_sout  <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_state <= SHIFT;
      r_cnt   <= '0;
      r_shift <= w_load_rest;
      r_sout  <= w_first_bit;
      r_valid <= 1'b1;
    end else if ((r_state == SHIFT) && shift_en) begin
      if (r_cnt == LAST_CNT) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_shift <= '0;
        r_sout  <= 1'b0;
        r_valid <= 1'b0;
      end else begin
        r_cnt   <= r_cnt + CW'(1);
        r_sout  <= MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
        r_shift <= MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
      end
    end
  end

  assign sout        = r_sout;
  assign sout_valid  = r_valid;
  assign frame_start = r_valid && (r_cnt == '0);
  assign last        = w_last;
  assign dbg_state   = r_state;

endmodule
